seven_segment_capture: RTL and testbench

- Receive-side counterpart of the team's BCD-to-seven-segment encoder.
- Monitors a multiplexed 4-digit common-anode display bus (segment lines plus anode selects). Reconstructs the BCD digit shown at each position and flags illegal patterns.
- Delivers complete 4-digit frames over a valid/ready handshake.
- Used in self-checking display paths and as a loopback monitor on the display driver outputs.

---
 rtl/seven_segment_pkg.sv | 26 ++
 rtl/seven_segment_capture_decode.sv | 32 +++
 rtl/seven_segment_capture.sv | 201 ++++++++++++++++++++
 tb/tb_seven_segment_capture.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment capture path.
//   - Legal common-anode segment patterns, ordered {g,f,e,d,c,b,a}, 1 = lit.
//   - BCD_ILLEGAL: code reported for any pattern that is not a decimal digit.
//   - state_t: states of the per-dwell sampling FSM.
package seven_segment_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [3:0] BCD_ILLEGAL = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no digit being driven
    TRACK = 2'd1,  // counting identical samples of one digit
    DONE  = 2'd2   // digit captured; waiting for the dwell to end
  } state_t;

endpackage

// File: rtl/seven_segment_capture_decode.sv
// seg_pattern_decode: combinational seven-segment to BCD decoder.
//   i_seg [6:0] : segment pattern {g,f,e,d,c,b,a}, active-high
//   o_bcd [3:0] : decoded digit 0..9, or BCD_ILLEGAL
//   o_err       : 1 when the pattern is not a legal digit (blank included)
module seg_pattern_decode
  import seven_segment_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_err
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs (no latch).
    o_bcd = BCD_ILLEGAL;
    o_err = 1'b1;
    case (i_seg)
      SEG_0: begin o_bcd = 4'd0; o_err = 1'b0; end
      SEG_1: begin o_bcd = 4'd1; o_err = 1'b0; end
      SEG_2: begin o_bcd = 4'd2; o_err = 1'b0; end
      SEG_3: begin o_bcd = 4'd3; o_err = 1'b0; end
      SEG_4: begin o_bcd = 4'd4; o_err = 1'b0; end
      SEG_5: begin o_bcd = 4'd5; o_err = 1'b0; end
      SEG_6: begin o_bcd = 4'd6; o_err = 1'b0; end
      SEG_7: begin o_bcd = 4'd7; o_err = 1'b0; end
      SEG_8: begin o_bcd = 4'd8; o_err = 1'b0; end
      SEG_9: begin o_bcd = 4'd9; o_err = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: monitors a multiplexed 4-digit common-anode display
// bus, rebuilds the BCD digit at each position and hands out whole frames
// over a valid/ready handshake.
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   seg [6:0]    : segment lines {g,f,e,d,c,b,a}, 1 = lit
//   an_n [3:0]   : anode selects, active-low, one low = digit driven
//   frame_valid  : a captured frame is presented
//   frame_ready  : consumer accepts the frame when high with frame_valid
//   frame_bcd    : {digit3,digit2,digit1,digit0}, 4'hF = illegal pattern
//   frame_err    : per-digit illegal-pattern flags
//   overflow     : sticky, a complete frame was dropped during a stall
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an_n,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [15:0] frame_bcd,
  output logic [3:0]  frame_err,
  output logic        overflow
);

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

  // Registered copy of the pins; everything below works on this sample.
  logic [6:0]       r_seg;
  logic [3:0]       r_an_n;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [6:0]       r_pat;
  logic [3:0]       r_seen;
  logic [15:0]      r_slot_bcd;
  logic [3:0]       r_slot_err;

  logic             r_frame_valid;
  logic [15:0]      r_frame_bcd;
  logic [3:0]       r_frame_err;
  logic             r_overflow;

  logic             w_an_ok;
  logic [1:0]       w_an_idx;
  logic [3:0]       w_dec_bcd;
  logic             w_dec_err;
  logic             w_same;
  logic             w_enter;
  logic             w_cap;
  logic [CNT_W-1:0] w_cnt_inc;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_idx_nxt;
  logic [6:0]       w_pat_nxt;
  logic [15:0]      w_slot_bcd_nxt;
  logic [3:0]       w_slot_err_nxt;
  logic [3:0]       w_seen_nxt;
  logic             w_frame_done;
  logic             w_out_free;
  logic             w_load;
  logic             w_drop;

  seg_pattern_decode u_decode (
    .i_seg (r_seg),
    .o_bcd (w_dec_bcd),
    .o_err (w_dec_err)
  );

  // Exactly one low anode selects a digit; blank or multi-low is "no digit".
  always_comb begin
    w_an_ok  = 1'b1;
    w_an_idx = 2'd0;
    case (r_an_n)
      4'b1110: w_an_idx = 2'd0;
      4'b1101: w_an_idx = 2'd1;
      4'b1011: w_an_idx = 2'd2;
      4'b0111: w_an_idx = 2'd3;
      default: w_an_ok  = 1'b0;
    endcase
  end

  assign w_same    = w_an_ok && (w_an_idx == r_idx) && (r_seg == r_pat);
  assign w_cnt_inc = (r_cnt == STABLE_CNT) ? r_cnt : r_cnt + 1'b1;

  // Sampling FSM: next state, counter and capture strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_pat_nxt   = r_pat;
    w_cap       = 1'b0;
    w_enter     = 1'b0;

    case (r_state)
      IDLE:  w_enter = 1'b1;
      TRACK: begin
        if (w_same) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == STABLE_CNT) begin
            w_cap       = 1'b1;
            w_state_nxt = DONE;
          end
        end else begin
          w_enter = 1'b1;
        end
      end
      DONE:    if (!w_same) w_enter = 1'b1;
      default: w_enter = 1'b1;
    endcase

    // Fresh dwell: the first sample already counts as one.
    if (w_enter) begin
      if (w_an_ok) begin
        w_state_nxt = TRACK;
        w_idx_nxt   = w_an_idx;
        w_pat_nxt   = r_seg;
        w_cnt_nxt   = CNT_W'(1);
        if (STABLE_CYCLES == 1) begin
          w_cap       = 1'b1;
          w_state_nxt = DONE;
        end
      end else begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    end
  end

  // Working slots with this cycle's capture merged in, so a frame that
  // completes on this capture carries the newly written digit.
  always_comb begin
    w_slot_bcd_nxt = r_slot_bcd;
    w_slot_err_nxt = r_slot_err;
    w_seen_nxt     = r_seen;
    if (w_cap) begin
      w_slot_bcd_nxt[{w_an_idx, 2'b00} +: 4] = w_dec_bcd;
      w_slot_err_nxt[w_an_idx]               = w_dec_err;
      w_seen_nxt[w_an_idx]                   = 1'b1;
    end
  end

  assign w_frame_done = &w_seen_nxt;
  assign w_out_free   = !r_frame_valid || frame_ready;
  assign w_load       = w_frame_done && w_out_free;
  assign w_drop       = w_frame_done && !w_out_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg         <= '0;
      r_an_n        <= 4'hF;
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_pat         <= '0;
      r_seen        <= '0;
      // NOTE: the working slots are only four digits, so they are reset
      // explicitly rather than left to hold stale power-up contents.
      r_slot_bcd    <= '0;
      r_slot_err    <= '0;
      r_frame_valid <= 1'b0;
      r_frame_bcd   <= '0;
      r_frame_err   <= '0;
      r_overflow    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register sees pre-edge values.
      r_seg      <= seg;
      r_an_n     <= an_n;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_pat      <= w_pat_nxt;
      r_slot_bcd <= w_slot_bcd_nxt;
      r_slot_err <= w_slot_err_nxt;
      r_seen     <= w_frame_done ? 4'b0000 : w_seen_nxt;

      if (w_load) begin
        r_frame_valid <= 1'b1;
        r_frame_bcd   <= w_slot_bcd_nxt;
        r_frame_err   <= w_slot_err_nxt;
      end else if (r_frame_valid && frame_ready) begin
        r_frame_valid <= 1'b0;
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign frame_valid = r_frame_valid;
  assign frame_bcd   = r_frame_bcd;
  assign frame_err   = r_frame_err;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture (STABLE_CYCLES = 4).
module tb_seven_segment_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h00;
  logic [3:0]  an_n = 4'hF;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic [15:0] frame_bcd;
  logic [3:0]  frame_err;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int n_accept = 0;
  logic [15:0] last_bcd = '0;
  logic [3:0]  last_err = '0;

  seven_segment_capture #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an_n        (an_n),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_bcd   (frame_bcd),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Record each handshake; inputs change just after posedge, so the
  // negedge view is what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst && frame_valid && frame_ready) begin
      n_accept = n_accept + 1;
      last_bcd = frame_bcd;
      last_err = frame_err;
    end
  end

  // Hold one anode/pattern for n cycles; returns 1 time unit after a posedge.
  task automatic drive(input logic [3:0] an, input logic [6:0] pat, input int n);
    an_n = an;
    seg  = pat;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
    drive(4'b1110, p0, 8);
    drive(4'b1101, p1, 8);
    drive(4'b1011, p2, 8);
    drive(4'b0111, p3, 8);
    drive(4'b1111, 7'h00, 8);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    do_reset();
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", frame_valid); else n_pass++;
    n_checks++; if (frame_bcd !== 16'h0000) $display("FAIL reset_bcd got %h want 0000", frame_bcd); else n_pass++;
    n_checks++; if (frame_err !== 4'b0000) $display("FAIL reset_err got %b want 0000", frame_err); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_frame_capture();
    int a0;
    frame_ready = 1'b1;
    a0 = n_accept;
    scan4(7'h4F, 7'h06, 7'h66, 7'h06);  // 3,1,4,1
    n_checks++; if (n_accept - a0 !== 1) $display("FAIL capture_count got %0d want 1", n_accept - a0); else n_pass++;
    n_checks++; if (last_bcd !== 16'h1413) $display("FAIL capture_bcd got %h want 1413", last_bcd); else n_pass++;
    n_checks++; if (last_err !== 4'b0000) $display("FAIL capture_err got %b want 0000", last_err); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL capture_overflow got %b want 0", overflow); else n_pass++;
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL capture_valid_drop got %b want 0", frame_valid); else n_pass++;
  endtask

  task automatic test_glitch();
    int a0;
    a0 = n_accept;
    drive(4'b1110, 7'h3F, 8);  // 0
    drive(4'b1101, 7'h5B, 8);  // 2
    drive(4'b1011, 7'h7F, 3);  // 8, too short to capture
    drive(4'b1011, 7'h6D, 6);  // 5
    drive(4'b0111, 7'h6F, 8);  // 9
    drive(4'b1111, 7'h00, 8);
    n_checks++; if (n_accept - a0 !== 1) $display("FAIL glitch_count got %0d want 1", n_accept - a0); else n_pass++;
    n_checks++; if (last_bcd !== 16'h9520) $display("FAIL glitch_bcd got %h want 9520", last_bcd); else n_pass++;
  endtask

  task automatic test_illegal();
    scan4(7'h00, 7'h06, 7'h5B, 7'h4F);
    n_checks++; if (last_bcd !== 16'h321F) $display("FAIL blank_bcd got %h want 321F", last_bcd); else n_pass++;
    n_checks++; if (last_err !== 4'b0001) $display("FAIL blank_err got %b want 0001", last_err); else n_pass++;
    drive(4'b1110, 7'h76, 6);
    drive(4'b1101, 7'h06, 8);
    drive(4'b1011, 7'h5B, 8);
    drive(4'b0111, 7'h4F, 8);
    drive(4'b1111, 7'h00, 8);
    n_checks++; if (last_bcd !== 16'h321F) $display("FAIL h_pattern_bcd got %h want 321F", last_bcd); else n_pass++;
    n_checks++; if (last_err !== 4'b0001) $display("FAIL h_pattern_err got %b want 0001", last_err); else n_pass++;
  endtask

  task automatic test_backpressure();
    int a0;
    frame_ready = 1'b0;
    a0 = n_accept;
    scan4(7'h6D, 7'h7D, 7'h07, 7'h7F);  // 5,6,7,8
    n_checks++; if (frame_valid !== 1'b1) $display("FAIL stall_valid got %b want 1", frame_valid); else n_pass++;
    n_checks++; if (frame_bcd !== 16'h8765) $display("FAIL stall_bcd got %h want 8765", frame_bcd); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL stall_no_overflow_yet got %b want 0", overflow); else n_pass++;
    scan4(7'h3F, 7'h3F, 7'h3F, 7'h3F);
    n_checks++; if (frame_bcd !== 16'h8765) $display("FAIL stall_hold_bcd got %h want 8765", frame_bcd); else n_pass++;
    n_checks++; if (frame_err !== 4'b0000) $display("FAIL stall_hold_err got %b want 0000", frame_err); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL stall_overflow got %b want 1", overflow); else n_pass++;
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL release_valid got %b want 0", frame_valid); else n_pass++;
    n_checks++; if (n_accept - a0 !== 1) $display("FAIL release_count got %0d want 1", n_accept - a0); else n_pass++;
    n_checks++; if (last_bcd !== 16'h8765) $display("FAIL release_bcd got %h want 8765", last_bcd); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL overflow_sticky got %b want 1", overflow); else n_pass++;
  endtask

  task automatic test_blank_multi();
    int a0;
    frame_ready = 1'b1;
    a0 = n_accept;
    drive(4'b1110, 7'h07, 8);  // 7 on position 0
    drive(4'b1111, 7'h3F, 6);  // blank
    drive(4'b1100, 7'h3F, 6);  // two anodes low
    drive(4'b1101, 7'h06, 8);  // 1
    drive(4'b1011, 7'h5B, 8);  // 2
    drive(4'b0011, 7'h06, 6);
    n_checks++; if (n_accept - a0 !== 0) $display("FAIL no_early_frame got %0d want 0", n_accept - a0); else n_pass++;
    drive(4'b0111, 7'h4F, 8);  // 3
    drive(4'b1111, 7'h00, 8);
    n_checks++; if (n_accept - a0 !== 1) $display("FAIL multi_count got %0d want 1", n_accept - a0); else n_pass++;
    n_checks++; if (last_bcd !== 16'h3217) $display("FAIL multi_bcd got %h want 3217", last_bcd); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int a0;
    frame_ready = 1'b1;
    drive(4'b1110, 7'h6F, 8);  // 9
    drive(4'b1101, 7'h7F, 8);  // 8
    do_reset();
    n_checks++; if (overflow !== 1'b0) $display("FAIL midreset_overflow got %b want 0", overflow); else n_pass++;
    n_checks++; if (frame_bcd !== 16'h0000) $display("FAIL midreset_bcd got %h want 0000", frame_bcd); else n_pass++;
    a0 = n_accept;
    drive(4'b1011, 7'h7D, 8);  // 6 on pos 2
    drive(4'b0111, 7'h07, 8);  // 7 on pos 3
    drive(4'b1110, 7'h66, 8);  // 4 on pos 0
    drive(4'b1101, 7'h6D, 8);  // 5 on pos 1
    drive(4'b1111, 7'h00, 8);
    n_checks++; if (n_accept - a0 !== 1) $display("FAIL midreset_count got %0d want 1", n_accept - a0); else n_pass++;
    n_checks++; if (last_bcd !== 16'h7654) $display("FAIL midreset_frame got %h want 7654", last_bcd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame_capture();
    test_glitch();
    test_illegal();
    test_backpressure();
    test_blank_multi();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
